// File: rtl/i2s_rx_tdm.sv
// i2s_rx_tdm
//
// Multi-line I2S / TDM receiver. LINES serial data pins share one bit clock
// (qualified here by the one-cycle 'sample' strobe) and one word select
// (represented by 'frame_posn'). Every frame yields 2*LINES channel words.
// The frame is buffered and streamed out over valid/ready in the order
// L0,R0,L1,R1,... If a frame completes while the previous one is still
// being drained, the new frame is discarded and 'overrun' is set.
//
// Parameters:
//   BITS   sample width, 8..24
//   CLOCKS bit clocks per frame, 32 or 64
//   LINES  number of data pins, 1..8
//   OFFSET bit delay after the word-select edge (1 = I2S, 0 = left-justified);
//          OFFSET+BITS must not exceed CLOCKS/2
//
// Ports:
//   ck, rst      system clock, synchronous active-high reset
//   sample       strobe; sd and frame_posn are used only when high
//   frame_posn   bit position within the frame
//   sd           serial data, bit n = line n
//   out_data     channel word
//   out_chan     channel index = 2*line + (1 for right)
//   out_valid    out_data/out_chan valid
//   out_last     final channel of the frame
//   out_ready    downstream accept
//   overrun      sticky frame-dropped flag
//   clr_overrun  clears overrun (a coincident drop wins)
//   out_frame    (I2S_RX_FRAMECOUNT_EN only) frame sequence number,
//                counts every right capture, dropped ones included
//
// Optional feature macro: I2S_RX_FRAMECOUNT_EN

module i2s_rx_tdm #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned CLOCKS = 64,
  parameter int unsigned LINES  = 4,
  parameter int unsigned OFFSET = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             sample,
  input  logic [5:0]       frame_posn,
  input  logic [LINES-1:0] sd,
  output logic [BITS-1:0]  out_data,
  output logic [3:0]       out_chan,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun
`ifdef I2S_RX_FRAMECOUNT_EN
  ,
  output logic [15:0]      out_frame
`endif
);

  localparam int unsigned NCH      = 2 * LINES;
  localparam logic [5:0]  MASK     = (CLOCKS == 64) ? 6'h3F : 6'h1F;
  localparam logic [5:0]  EOW_L    = MASK & 6'(OFFSET + BITS);
  localparam logic [5:0]  EOW_R    = MASK & 6'(OFFSET + BITS + CLOCKS / 2);
  localparam logic [3:0]  LAST_IDX = 4'(NCH - 1);

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_t;

  buf_state_t      state;
  logic [BITS-1:0] shreg      [LINES];
  logic [BITS-1:0] left_stage [LINES];
  logic [BITS-1:0] frame_buf  [NCH];
  logic [3:0]      idx;

  logic [5:0]      frame;
  logic            cap_l;
  logic            cap_r;
  logic            hs;
  logic            last_hs;
  logic            buf_free;
  logic            load;
  logic            drop;
  logic [3:0]      idx_nxt;
  logic [BITS-1:0] next_word;

  always_comb begin
    frame    = frame_posn & MASK;
    cap_l    = sample && (frame == EOW_L);
    cap_r    = sample && (frame == EOW_R);
    hs       = out_valid && out_ready;
    last_hs  = hs && (idx == LAST_IDX);
    // The buffer counts as free when the last word leaves on this very edge,
    // so a coincident frame completion reloads instead of dropping.
    buf_free = (state == BUF_EMPTY) || last_hs;
    load     = cap_r && buf_free;
    drop     = cap_r && !buf_free;
    idx_nxt  = idx + 4'd1;
    next_word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (4'(i) == idx_nxt) next_word = frame_buf[i];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned n = 0; n < LINES; n++) begin
        shreg[n]      <= '0;
        left_stage[n] <= '0;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        frame_buf[i] <= '0;
      end
      state     <= BUF_EMPTY;
      idx       <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample) begin
        for (int unsigned n = 0; n < LINES; n++) begin
          shreg[n] <= {shreg[n][BITS-2:0], sd[n]};
        end
      end

      // Captures use the pre-shift register contents: at the end-of-word
      // position the register holds exactly the BITS bits just received.
      if (cap_l) begin
        for (int unsigned n = 0; n < LINES; n++) begin
          left_stage[n] <= shreg[n];
        end
      end

      if (load) begin
        for (int unsigned n = 0; n < LINES; n++) begin
          frame_buf[2*n]   <= left_stage[n];
          frame_buf[2*n+1] <= shreg[n];
        end
        state     <= BUF_FULL;
        idx       <= '0;
        out_valid <= 1'b1;
        out_chan  <= '0;
        out_data  <= left_stage[0];
        out_last  <= 1'b0;
      end else if (last_hs) begin
        state     <= BUF_EMPTY;
        idx       <= '0;
        out_valid <= 1'b0;
        out_chan  <= '0;
        out_last  <= 1'b0;
      end else if (hs) begin
        idx      <= idx_nxt;
        out_chan <= idx_nxt;
        out_data <= next_word;
        out_last <= (idx_nxt == LAST_IDX);
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_FRAMECOUNT_EN
  logic [15:0] frame_cnt;

  // out_frame carries the count including the capture that loads the buffer.
  always_ff @(posedge ck) begin
    if (rst) begin
      frame_cnt <= '0;
      out_frame <= '0;
    end else begin
      if (cap_r) frame_cnt <= frame_cnt + 16'd1;
      if (load)  out_frame <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Directed bench for i2s_rx_tdm: a vector table of frames on a 2-line,
// 64-clock, I2S-offset instance, a 1-line 32-clock left-justified instance
// running alongside, and hand sequences for backpressure, overrun,
// coincident completion, reset mid-drain and the optional frame counter.

module tb_i2s_rx_tdm;

  logic        ck = 1'b0;
  logic        rst;
  logic        sample;
  logic [5:0]  frame_posn;
  logic [1:0]  sd;
  logic [15:0] out_data;
  logic [3:0]  out_chan;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        overrun;
  logic        clr_overrun;

  logic [0:0]  sd32;
  logic [15:0] out_data32;
  logic [3:0]  out_chan32;
  logic        out_valid32;
  logic        out_last32;
  logic        overrun32;
`ifdef I2S_RX_FRAMECOUNT_EN
  logic [15:0] out_frame;
  logic [15:0] out_frame32;
`endif

  always #5 ck = ~ck;

  i2s_rx_tdm #(.BITS(16), .CLOCKS(64), .LINES(2), .OFFSET(1)) dut (
    .ck(ck), .rst(rst), .sample(sample), .frame_posn(frame_posn), .sd(sd),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .overrun(overrun),
    .clr_overrun(clr_overrun)
`ifdef I2S_RX_FRAMECOUNT_EN
    , .out_frame(out_frame)
`endif
  );

  i2s_rx_tdm #(.BITS(16), .CLOCKS(32), .LINES(1), .OFFSET(0)) dut32 (
    .ck(ck), .rst(rst), .sample(sample), .frame_posn(frame_posn), .sd(sd32),
    .out_data(out_data32), .out_chan(out_chan32), .out_valid(out_valid32),
    .out_last(out_last32), .out_ready(1'b1), .overrun(overrun32),
    .clr_overrun(1'b0)
`ifdef I2S_RX_FRAMECOUNT_EN
    , .out_frame(out_frame32)
`endif
  );

  localparam logic [15:0] L32 = 16'hF00F;
  localparam logic [15:0] R32 = 16'h0FF0;

  int checks = 0;
  int errors = 0;
  int gpos   = 0;
  logic [15:0] cl0, cr0, cl1, cr1;

  typedef struct {
    logic [15:0] l0, r0, l1, r1;
    logic        gap;
    logic [15:0] e [4];
  } vec_t;

  vec_t vecs [4];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_c(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [3:0] ch,
                          input logic [15:0] d, input logic last);
    chk_b({name, "_valid"}, out_valid, 1'b1);
    chk_c({name, "_chan"}, out_chan, ch);
    chk_w({name, "_data"}, out_data, d);
    chk_b({name, "_last"}, out_last, last);
  endtask

  function automatic logic bit_of(input logic [15:0] w, input int i);
    logic [15:0] t;
    t = w >> i;
    return t[0];
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // One sampled bit clock at position gpos carrying the current frame data.
  task automatic step();
    int q;
    sample     = 1'b1;
    frame_posn = 6'(gpos);
    sd         = 2'($urandom);
    if (gpos >= 1 && gpos <= 16) begin
      sd[0] = bit_of(cl0, 16 - gpos);
      sd[1] = bit_of(cl1, 16 - gpos);
    end else if (gpos >= 33 && gpos <= 48) begin
      sd[0] = bit_of(cr0, 48 - gpos);
      sd[1] = bit_of(cr1, 48 - gpos);
    end
    q = gpos % 32;
    sd32[0] = (q < 16) ? bit_of(L32, 15 - q) : bit_of(R32, 31 - q);
    tick();
    gpos = (gpos + 1) % 64;
  endtask

  // Non-sampling cycle parked on the main instance's EOW_R with junk data.
  task automatic idle();
    sample     = 1'b0;
    frame_posn = 6'd49;
    sd         = 2'($urandom);
    sd32       = 1'($urandom);
    tick();
  endtask

  task automatic advance_to(input int p);
    for (int g = 0; g < 64 && gpos != p; g++) step();
  endtask

  task automatic set_frame(input logic [15:0] l0, r0, l1, r1);
    cl0 = l0; cr0 = r0; cl1 = l1; cr1 = r1;
  endtask

  task automatic check_cycle(input int p, input int k, input int k32, input vec_t v);
    if (p == 48 && k < 0) chk_b("pre_eowr_valid", out_valid, 1'b0);
    if (k >= 0 && k < 4) chk_word("vec_word", 4'(k), v.e[k], k == 3);
    if (k == 4) chk_b("vec_empty", out_valid, 1'b0);
    if (k32 == 0) begin
      chk_b("c32_valid0", out_valid32, 1'b1);
      chk_c("c32_chan0", out_chan32, 4'd0);
      chk_w("c32_left", out_data32, L32);
      chk_b("c32_last0", out_last32, 1'b0);
    end
    if (k32 == 1) begin
      chk_c("c32_chan1", out_chan32, 4'd1);
      chk_w("c32_right", out_data32, R32);
      chk_b("c32_last1", out_last32, 1'b1);
    end
    if (k32 == 2) chk_b("c32_empty", out_valid32, 1'b0);
  endtask

  initial begin
    vecs[0] = '{l0: 16'h1234, r0: 16'hABCD, l1: 16'h8001, r1: 16'h7FFE, gap: 1'b0,
                e: '{16'h1234, 16'hABCD, 16'h8001, 16'h7FFE}};
    vecs[1] = '{l0: 16'hFFFF, r0: 16'h0000, l1: 16'h0000, r1: 16'hFFFF, gap: 1'b1,
                e: '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}};
    vecs[2] = '{l0: 16'hA5A5, r0: 16'h5A5A, l1: 16'hC3C3, r1: 16'h3C3C, gap: 1'b0,
                e: '{16'hA5A5, 16'h5A5A, 16'hC3C3, 16'h3C3C}};
    vecs[3] = '{l0: 16'h0001, r0: 16'h8000, l1: 16'h7FFF, r1: 16'hFFFE, gap: 1'b1,
                e: '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFE}};

    rst = 1'b1; sample = 1'b0; frame_posn = '0; sd = '0; sd32 = '0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    set_frame('0, '0, '0, '0);
    repeat (3) tick();
    chk_b("rst_valid", out_valid, 1'b0);
    chk_c("rst_chan", out_chan, 4'd0);
    chk_w("rst_data", out_data, 16'h0000);
    chk_b("rst_last", out_last, 1'b0);
    chk_b("rst_overrun", overrun, 1'b0);
    chk_b("rst_valid32", out_valid32, 1'b0);
`ifdef I2S_RX_FRAMECOUNT_EN
    chk_w("rst_frame", out_frame, 16'd0);
    chk_w("rst_frame32", out_frame32, 16'd0);
`endif
    rst = 1'b0;
    gpos = 0;

    // Table-driven frames, ready held high; gap rows interleave sample-low cycles.
    for (int i = 0; i < 4; i++) begin
      int k, k32;
      set_frame(vecs[i].l0, vecs[i].r0, vecs[i].l1, vecs[i].r1);
      k = -1; k32 = -1;
      for (int p = 0; p < 64; p++) begin
        step();
        if (p == 49) k = 0; else if (k >= 0) k++;
        if (p == 32) k32 = 0; else if (k32 >= 0) k32++;
        check_cycle(p, k, k32, vecs[i]);
        if (vecs[i].gap) begin
          idle();
          if (k >= 0) k++;
          if (k32 >= 0) k32++;
          check_cycle(p, k, k32, vecs[i]);
        end
      end
    end
    chk_b("overrun32_quiet", overrun32, 1'b0);

    // Backpressure: word 0 frozen for 20 cycles, then ordered drain.
    set_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    out_ready = 1'b0;
    advance_to(50);
    chk_word("bp_w0", 4'd0, 16'h1111, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk_c("bp_hold_chan", out_chan, 4'd0);
      chk_w("bp_hold_data", out_data, 16'h1111);
      chk_b("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step(); chk_word("bp_w1", 4'd1, 16'h2222, 1'b0);
    step(); chk_word("bp_w2", 4'd2, 16'h3333, 1'b0);
    step(); chk_word("bp_w3", 4'd3, 16'h4444, 1'b1);
    step(); chk_b("bp_empty", out_valid, 1'b0);

    // Overrun: second and third frames dropped, first retained.
    advance_to(0);
    out_ready = 1'b0;
    set_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    advance_to(50);
    chk_word("ov_w0", 4'd0, 16'hDEAD, 1'b0);
    chk_b("ov_none", overrun, 1'b0);
    advance_to(0);
    set_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    advance_to(49);
    chk_b("ov_before", overrun, 1'b0);
    step();
    chk_b("ov_set", overrun, 1'b1);
    chk_w("ov_kept", out_data, 16'hDEAD);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk_b("ov_clr", overrun, 1'b0);
    advance_to(0);
    set_frame(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    advance_to(49);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk_b("ov_set_wins", overrun, 1'b1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk_b("ov_clr2", overrun, 1'b0);
    out_ready = 1'b1;
    chk_word("ov_d0", 4'd0, 16'hDEAD, 1'b0);
    step(); chk_word("ov_d1", 4'd1, 16'hBEEF, 1'b0);
    step(); chk_word("ov_d2", 4'd2, 16'hCAFE, 1'b0);
    step(); chk_word("ov_d3", 4'd3, 16'hF00D, 1'b1);
    step(); chk_b("ov_empty", out_valid, 1'b0);

    // Coincident: last handshake lands on the EOW_R edge.
    advance_to(0);
    set_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    out_ready = 1'b0;
    advance_to(50);
    chk_word("co_w0", 4'd0, 16'h0102, 1'b0);
    advance_to(0);
    set_frame(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    advance_to(46);
    out_ready = 1'b1;
    step(); chk_word("co_w1", 4'd1, 16'h0304, 1'b0);
    step(); chk_word("co_w2", 4'd2, 16'h0506, 1'b0);
    step(); chk_word("co_w3", 4'd3, 16'h0708, 1'b1);
    step();
    chk_word("co_new0", 4'd0, 16'hAAAA, 1'b0);
    chk_b("co_no_overrun", overrun, 1'b0);
    step(); chk_word("co_new1", 4'd1, 16'hBBBB, 1'b0);
    step(); chk_word("co_new2", 4'd2, 16'hCCCC, 1'b0);
    step(); chk_word("co_new3", 4'd3, 16'hDDDD, 1'b1);
    step(); chk_b("co_empty", out_valid, 1'b0);

    // Reset mid-drain with overrun pending.
    out_ready = 1'b0;
    advance_to(0);
    set_frame(16'h1357, 16'h2468, 16'h9BDF, 16'hACE0);
    advance_to(50);
    advance_to(0);
    advance_to(50);
    chk_b("rs_overrun", overrun, 1'b1);
    out_ready = 1'b1;
    step(); step();
    chk_word("rs_mid", 4'd2, 16'h9BDF, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk_b("rs_valid", out_valid, 1'b0);
    chk_c("rs_chan", out_chan, 4'd0);
    chk_w("rs_data", out_data, 16'h0000);
    chk_b("rs_last", out_last, 1'b0);
    chk_b("rs_overrun_clr", overrun, 1'b0);
`ifdef I2S_RX_FRAMECOUNT_EN
    chk_w("rs_frame", out_frame, 16'd0);
`endif

    // Frame numbering across a dropped frame.
    out_ready = 1'b0;
    advance_to(0);
    advance_to(50);
    chk_word("fc_w0", 4'd0, 16'h1357, 1'b0);
`ifdef I2S_RX_FRAMECOUNT_EN
    chk_w("fc_first", out_frame, 16'd1);
`endif
    advance_to(0);
    advance_to(50);
    chk_b("fc_drop", overrun, 1'b1);
    out_ready = 1'b1;
    step(); chk_word("fc_d1", 4'd1, 16'h2468, 1'b0);
`ifdef I2S_RX_FRAMECOUNT_EN
    chk_w("fc_hold1", out_frame, 16'd1);
`endif
    step(); chk_word("fc_d2", 4'd2, 16'h9BDF, 1'b0);
    step(); chk_word("fc_d3", 4'd3, 16'hACE0, 1'b1);
`ifdef I2S_RX_FRAMECOUNT_EN
    chk_w("fc_hold3", out_frame, 16'd1);
`endif
    step(); chk_b("fc_empty", out_valid, 1'b0);
    advance_to(0);
    advance_to(50);
    chk_word("fc_third", 4'd0, 16'h1357, 1'b0);
`ifdef I2S_RX_FRAMECOUNT_EN
    chk_w("fc_third_num", out_frame, 16'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
